// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_F    = 2'd1,
        OWNER_D_RD = 2'd2,
        OWNER_D_WR = 2'd3
    } resp_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation tracker: raises force_fetch once data has won STARVE_MAX
// consecutive grants while fetch was waiting.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    input  logic f_gnt,
    input  logic d_gnt,
    output logic force_fetch
);

    localparam logic [STARVE_W-1:0] CREDIT_LOAD = STARVE_W'(STARVE_MAX);

    // Counts down the data grants fetch may still lose; zero is terminal count.
    logic [STARVE_W-1:0] credit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CREDIT_LOAD;
        end else if (f_gnt || !f_req) begin
            credit_q <= CREDIT_LOAD;
        end else if (d_gnt && (credit_q != '0)) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    assign force_fetch = f_req && (credit_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store, one grant per cycle,
// responses routed one cycle later. Optional perf counters under MEM_ARB_PERF_EN.
//
// owner_q    | meaning
// OWNER_NONE | no response due this cycle
// OWNER_F    | fetch read data on mem_data_i
// OWNER_D_RD | load data on mem_data_i
// OWNER_D_WR | store acknowledge, no data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_i,
    input  logic [AWIDTH-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DWIDTH-1:0] f_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt_o,
    output logic [31:0]       starve_cnt_o
`endif
);

    logic              force_fetch;
    logic              f_win;
    logic              d_win;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] f_rdata_q;
    logic [DWIDTH-1:0] d_rdata_q;
    resp_owner_e       owner_q;
    resp_owner_e       owner_d;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .f_req       (f_req_i),
        .f_gnt       (f_win),
        .d_gnt       (d_win),
        .force_fetch (force_fetch)
    );

    assign f_win = f_req_i && (force_fetch || !d_req_i);
    assign d_win = d_req_i && !f_win;

    // Outputs are masked by reset directly so they clear asynchronously even
    // while requests stay high; flops see the unmasked decision.
    assign f_gnt_o        = f_win && !rst;
    assign d_gnt_o        = d_win && !rst;
    assign mem_read_en_o  = f_gnt_o || (d_gnt_o && !d_we_i);
    assign mem_write_en_o = d_gnt_o && d_we_i;
    assign mem_addr_o     = f_gnt_o ? f_addr_i : (d_gnt_o ? d_addr_i : addr_q);
    assign mem_data_o     = mem_write_en_o ? d_wdata_i : wdata_q;

    always_comb begin
        owner_d = OWNER_NONE;
        if (f_win) begin
            owner_d = OWNER_F;
        end else if (d_win) begin
            owner_d = d_we_i ? OWNER_D_WR : OWNER_D_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWNER_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (f_win) begin
                addr_q <= f_addr_i;
            end else if (d_win) begin
                addr_q <= d_addr_i;
                if (d_we_i) begin
                    wdata_q <= d_wdata_i;
                end
            end
        end
    end

    assign f_rvalid_o = (owner_q == OWNER_F);
    assign d_rvalid_o = (owner_q == OWNER_D_RD) || (owner_q == OWNER_D_WR);
    assign f_rdata_o  = f_rvalid_o ? mem_data_i : f_rdata_q;

    always_comb begin
        d_rdata_o = d_rdata_q;
        if (owner_q == OWNER_D_RD) begin
            d_rdata_o = mem_data_i;
        end else if (owner_q == OWNER_D_WR) begin
            d_rdata_o = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (f_rvalid_o) begin
                f_rdata_q <= f_rdata_o;
            end
            if (d_rvalid_o) begin
                d_rdata_q <= d_rdata_o;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic [31:0] starve_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
            starve_q   <= '0;
        end else begin
            if (f_req_i && d_req_i) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (f_win && force_fetch) begin
                starve_q <= starve_q + 32'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign starve_cnt_o   = starve_q;
`endif

endmodule
